id_ex_alu_driver: RTL and testbench
===================================

ID_EX_ALU_DRIVER -- requirements
Module: id_ex_alu_driver

Interface
REQ-001 Parameter FWD_EN, default 1, enables EX/MEM and MEM/WB operand forwarding; 0 selects registered register-file data only.
REQ-002 One clock; reset is synchronous and active-high. Ports: clk and reset.
REQ-003 clk  in  1  rising-edge clock.
REQ-004 reset  in  1  synchronous active-high reset.
REQ-005 id_valid  in  1  ID stage holds a valid instruction.
REQ-006 stall  in  1  hold the EX register contents.
REQ-007 flush  in  1  replace the EX register contents with a bubble.
REQ-008 id_alu_op  in  2 and id_funct  in  6  ALU operation class and R-type funct field.
REQ-009 id_alu_src  in  1 and id_reg_write  in  1  immediate-select and writeback enable.
REQ-010 id_rs, id_rt, id_rd_dst  in  5 each  source and destination register numbers.
REQ-011 id_rs_data, id_rt_data  in  32 each and id_imm  in  16  register-file data and immediate.
REQ-012 exmem_reg_write  in  1, exmem_rd  in  5, exmem_result  in  32  EX/MEM forwarding source.
REQ-013 memwb_reg_write  in  1, memwb_rd  in  5, memwb_result  in  32  MEM/WB forwarding source.
REQ-014 Read_data_1, Data_2  out  32 each and ALU_control  out  3  ALU operands and operation code.
REQ-015 ex_valid, ex_reg_write  out  1 each and ex_rd  out  5  EX-stage status and destination.
REQ-016 ex_store_data  out  32 and illegal_funct  out  1  forwarded rt value and undecodable-funct flag.

Function
REQ-017 ALU_control codes: AND=0, OR=1, ADD=2, SUB=6, SLT=7; no other code is ever driven.
REQ-018 Decode at capture: alu_op 00 maps to ADD, 01 to SUB, and 11 to OR.
REQ-019 Decode at capture for alu_op 10, by funct: 100000 maps to ADD, 100010 to SUB, 100100 to AND, 100101 to OR, 101010 to SLT.
REQ-020 An alu_op 10 with any other funct decodes to ADD, registers illegal_funct=1, and forces ex_reg_write=0.
REQ-021 Capture on each clk edge when stall=0 and flush=0: the EX register loads id_valid, the decoded code, id_alu_src, id_reg_write&id_valid, the register numbers, both data words, and id_imm sign-extended to 32 bits.
REQ-022 Latency: a value presented on the ID inputs at edge N appears on the outputs after edge N, during cycle N+1.
REQ-023 stall=1 with flush=0: the EX register keeps its contents, and the forwarding muxes continue to track the current EX/MEM and MEM/WB inputs.
REQ-024 flush=1 loads a bubble regardless of stall, and flush takes priority when both are high.
REQ-025 Bubble contents: ex_valid=0, ex_reg_write=0, ex_rd=0, illegal_funct=0, code=ADD, all data fields 0.
REQ-026 Forwarding (combinational, from registered rs/rt): EX/MEM applies if exmem_reg_write=1, exmem_rd!=0, and exmem_rd equals the operand register.
REQ-027 Otherwise MEM/WB applies under the same conditions on memwb_*; otherwise the registered data is used.
REQ-028 EX/MEM wins when both forwarding sources match.
REQ-029 Register 0 is never forwarded; with FWD_EN=0 no forwarding occurs.
REQ-030 Read_data_1 is the forwarded rs value.
REQ-031 Data_2 is the sign-extended immediate if alu_src=1, else the forwarded rt value.
REQ-032 ex_store_data is always the forwarded rt value.
REQ-033 When ex_valid=0: Read_data_1=0, Data_2=0, ex_store_data=0, ALU_control=2.
REQ-034 All arithmetic is 32-bit; sign extension replicates id_imm[15] into bits 31:16.

Reset
REQ-035 reset=1 at a clk edge loads the bubble of REQ-025 and overrides stall and flush.
REQ-036 After reset: ex_valid=0, ex_reg_write=0, ex_rd=0, illegal_funct=0, ALU_control=2, Read_data_1=0, Data_2=0, ex_store_data=0.
REQ-037 reset asserted mid-stall discards the held instruction.

Verification
REQ-038 alu_op=10, funct=101010, rs_data=5, rt_data=9, no matches -> next cycle ALU_control=7, Read_data_1=5, Data_2=9, ex_valid=1.
REQ-039 alu_op=00, alu_src=1, imm=0xFFFC -> Data_2=0xFFFFFFFC, ALU_control=2.
REQ-040 Registered rs=rt=8; exmem_rd=8 with exmem_result=0x11; memwb_rd=8 with memwb_result=0x22; both reg_write=1 -> Read_data_1=0x11, Data_2=0x11.
REQ-041 Same setup as REQ-040 with exmem_rd=0 -> both operands 0x22.
REQ-042 Instruction A captured, then stall=1 for 3 cycles with new ID inputs -> outputs remain A; stall=1 with flush=1 -> bubble per REQ-033.
REQ-043 alu_op=10, funct=000000, reg_write=1 -> illegal_funct=1, ALU_control=2, ex_reg_write=0; reset=1 next edge -> all outputs per REQ-036.

Source files
------------

// File: rtl/id_ex_alu_driver.sv
// ID/EX pipeline register: decodes the ALU operation at capture and forwards EX/MEM, MEM/WB results into the operands.
// Latency: one clk from ID capture to outputs; forwarding muxes are combinational. stall holds, flush/reset insert a bubble.
module id_ex_alu_driver #(
  parameter int FWD_EN = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        id_valid,
  input  logic        stall,
  input  logic        flush,
  input  logic [1:0]  id_alu_op,
  input  logic [5:0]  id_funct,
  input  logic        id_alu_src,
  input  logic        id_reg_write,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic [4:0]  id_rd_dst,
  input  logic [31:0] id_rs_data,
  input  logic [31:0] id_rt_data,
  input  logic [15:0] id_imm,
  input  logic        exmem_reg_write,
  input  logic [4:0]  exmem_rd,
  input  logic [31:0] exmem_result,
  input  logic        memwb_reg_write,
  input  logic [4:0]  memwb_rd,
  input  logic [31:0] memwb_result,
  output logic [31:0] Read_data_1,
  output logic [31:0] Data_2,
  output logic [2:0]  ALU_control,
  output logic        ex_valid,
  output logic        ex_reg_write,
  output logic [4:0]  ex_rd,
  output logic [31:0] ex_store_data,
  output logic        illegal_funct
);
  localparam logic [2:0] ALU_AND = 3'd0;
  localparam logic [2:0] ALU_OR  = 3'd1;
  localparam logic [2:0] ALU_ADD = 3'd2;
  localparam logic [2:0] ALU_SUB = 3'd6;
  localparam logic [2:0] ALU_SLT = 3'd7;

  logic [2:0]  dec_code;
  logic        dec_illegal;
  logic [2:0]  ex_code;
  logic        ex_alu_src;
  logic [4:0]  ex_rs;
  logic [4:0]  ex_rt;
  logic [31:0] ex_rs_data;
  logic [31:0] ex_rt_data;
  logic [31:0] ex_imm;
  logic [31:0] rs_fwd;
  logic [31:0] rt_fwd;
  logic        exmem_ok;
  logic        memwb_ok;

  always_comb begin
    dec_code    = ALU_ADD;
    dec_illegal = 1'b0;
    case (id_alu_op)
      2'b00: dec_code = ALU_ADD;
      2'b01: dec_code = ALU_SUB;
      2'b11: dec_code = ALU_OR;
      default: begin
        case (id_funct)
          6'b100000: dec_code = ALU_ADD;
          6'b100010: dec_code = ALU_SUB;
          6'b100100: dec_code = ALU_AND;
          6'b100101: dec_code = ALU_OR;
          6'b101010: dec_code = ALU_SLT;
          default:   dec_illegal = 1'b1;
        endcase
      end
    endcase
  end

  // Reset and flush both load a bubble and outrank stall.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      ex_valid      <= 1'b0;
      ex_reg_write  <= 1'b0;
      ex_rd         <= 5'd0;
      illegal_funct <= 1'b0;
      ex_code       <= ALU_ADD;
      ex_alu_src    <= 1'b0;
      ex_rs         <= 5'd0;
      ex_rt         <= 5'd0;
      ex_rs_data    <= 32'd0;
      ex_rt_data    <= 32'd0;
      ex_imm        <= 32'd0;
    end else if (!stall) begin
      ex_valid      <= id_valid;
      ex_reg_write  <= id_reg_write & id_valid & ~dec_illegal;
      ex_rd         <= id_rd_dst;
      illegal_funct <= dec_illegal;
      ex_code       <= dec_code;
      ex_alu_src    <= id_alu_src;
      ex_rs         <= id_rs;
      ex_rt         <= id_rt;
      ex_rs_data    <= id_rs_data;
      ex_rt_data    <= id_rt_data;
      ex_imm        <= {{16{id_imm[15]}}, id_imm};
    end
  end

  assign exmem_ok = (FWD_EN != 0) && exmem_reg_write && (exmem_rd != 5'd0);
  assign memwb_ok = (FWD_EN != 0) && memwb_reg_write && (memwb_rd != 5'd0);

  // EX/MEM is the younger result, so it is checked first.
  always_comb begin
    rs_fwd = ex_rs_data;
    if (exmem_ok && exmem_rd == ex_rs)      rs_fwd = exmem_result;
    else if (memwb_ok && memwb_rd == ex_rs) rs_fwd = memwb_result;
    rt_fwd = ex_rt_data;
    if (exmem_ok && exmem_rd == ex_rt)      rt_fwd = exmem_result;
    else if (memwb_ok && memwb_rd == ex_rt) rt_fwd = memwb_result;
  end

  assign Read_data_1   = ex_valid ? rs_fwd : 32'd0;
  assign ex_store_data = ex_valid ? rt_fwd : 32'd0;
  assign Data_2        = !ex_valid ? 32'd0 : (ex_alu_src ? ex_imm : rt_fwd);
  assign ALU_control   = ex_valid ? ex_code : ALU_ADD;

endmodule

// File: tb/tb_id_ex_alu_driver.sv
// Randomized and directed bench for id_ex_alu_driver against a behavioural instruction-record model.
module tb_id_ex_alu_driver;
  logic clk = 1'b0;
  logic reset = 1'b1, id_valid = 1'b0, stall = 1'b0, flush = 1'b0;
  logic [1:0]  id_alu_op = '0;
  logic [5:0]  id_funct = '0;
  logic        id_alu_src = 1'b0, id_reg_write = 1'b0;
  logic [4:0]  id_rs = '0, id_rt = '0, id_rd_dst = '0;
  logic [31:0] id_rs_data = '0, id_rt_data = '0;
  logic [15:0] id_imm = '0;
  logic        exmem_reg_write = 1'b0, memwb_reg_write = 1'b0;
  logic [4:0]  exmem_rd = '0, memwb_rd = '0;
  logic [31:0] exmem_result = '0, memwb_result = '0;
  logic [31:0] Read_data_1, Data_2, ex_store_data;
  logic [2:0]  ALU_control;
  logic        ex_valid, ex_reg_write, illegal_funct;
  logic [4:0]  ex_rd;

  int n_checks = 0;
  int n_pass = 0;

  // Model: the instruction currently sitting in EX, as plain values.
  logic        m_valid, m_rw, m_ill, m_src;
  int          m_code;
  logic [4:0]  m_rs, m_rt, m_rd;
  logic [31:0] m_rsd, m_rtd, m_imm;
  logic [31:0] e_rd1, e_d2, e_st;
  int          e_alu;

  always #5 clk = ~clk;

  id_ex_alu_driver #(.FWD_EN(1)) dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .stall(stall), .flush(flush),
    .id_alu_op(id_alu_op), .id_funct(id_funct), .id_alu_src(id_alu_src),
    .id_reg_write(id_reg_write), .id_rs(id_rs), .id_rt(id_rt), .id_rd_dst(id_rd_dst),
    .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
    .exmem_reg_write(exmem_reg_write), .exmem_rd(exmem_rd), .exmem_result(exmem_result),
    .memwb_reg_write(memwb_reg_write), .memwb_rd(memwb_rd), .memwb_result(memwb_result),
    .Read_data_1(Read_data_1), .Data_2(Data_2), .ALU_control(ALU_control),
    .ex_valid(ex_valid), .ex_reg_write(ex_reg_write), .ex_rd(ex_rd),
    .ex_store_data(ex_store_data), .illegal_funct(illegal_funct)
  );

  // Opcode table; -1 marks an undecodable funct.
  function automatic int table_code(input logic [1:0] op, input logic [5:0] f);
    if (op == 2'b00) return 2;
    if (op == 2'b01) return 6;
    if (op == 2'b11) return 1;
    if (f == 6'd32) return 2;
    if (f == 6'd34) return 6;
    if (f == 6'd36) return 0;
    if (f == 6'd37) return 1;
    if (f == 6'd42) return 7;
    return -1;
  endfunction

  task automatic model_edge();
    int c;
    if (reset || flush) begin
      m_valid = 0; m_rw = 0; m_ill = 0; m_src = 0; m_code = 2;
      m_rs = 0; m_rt = 0; m_rd = 0; m_rsd = 0; m_rtd = 0; m_imm = 0;
    end else if (!stall) begin
      c = table_code(id_alu_op, id_funct);
      m_ill = (c < 0);
      m_code = m_ill ? 2 : c;
      m_valid = id_valid;
      m_rw = id_reg_write && id_valid && !m_ill;
      m_src = id_alu_src; m_rs = id_rs; m_rt = id_rt; m_rd = id_rd_dst;
      m_rsd = id_rs_data; m_rtd = id_rt_data;
      m_imm = $signed(id_imm);
    end
  endtask

  function automatic logic [31:0] fwd(input logic [4:0] r, input logic [31:0] d);
    if (exmem_reg_write && exmem_rd != 0 && exmem_rd == r) return exmem_result;
    if (memwb_reg_write && memwb_rd != 0 && memwb_rd == r) return memwb_result;
    return d;
  endfunction

  task automatic calc_exp();
    if (!m_valid) begin
      e_rd1 = 0; e_d2 = 0; e_st = 0; e_alu = 2;
    end else begin
      e_rd1 = fwd(m_rs, m_rsd);
      e_st = fwd(m_rt, m_rtd);
      e_d2 = m_src ? m_imm : e_st;
      e_alu = m_code;
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic set_id(input logic [1:0] op, input logic [5:0] f, input logic src, input logic rw,
                        input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                        input logic [31:0] rsd, input logic [31:0] rtd, input logic [15:0] imm);
    id_valid = 1; id_alu_op = op; id_funct = f; id_alu_src = src; id_reg_write = rw;
    id_rs = rs; id_rt = rt; id_rd_dst = rd; id_rs_data = rsd; id_rt_data = rtd; id_imm = imm;
  endtask

  task automatic no_fwd();
    exmem_reg_write = 0; memwb_reg_write = 0; exmem_rd = 0; memwb_rd = 0;
  endtask

  task automatic test_reset();
    reset = 1; stall = 1; flush = 0;
    step(); step();
    reset = 0; stall = 0;
    n_checks += 8;
    if (ex_valid !== 1'b0) $display("FAIL reset_valid got %0b exp 0", ex_valid); else n_pass++;
    if (ex_reg_write !== 1'b0) $display("FAIL reset_rw got %0b exp 0", ex_reg_write); else n_pass++;
    if (ex_rd !== 5'd0) $display("FAIL reset_rd got %0d exp 0", ex_rd); else n_pass++;
    if (illegal_funct !== 1'b0) $display("FAIL reset_ill got %0b exp 0", illegal_funct); else n_pass++;
    if (ALU_control !== 3'd2) $display("FAIL reset_alu got %0d exp 2", ALU_control); else n_pass++;
    if (Read_data_1 !== 32'd0) $display("FAIL reset_rd1 got %h exp 0", Read_data_1); else n_pass++;
    if (Data_2 !== 32'd0) $display("FAIL reset_d2 got %h exp 0", Data_2); else n_pass++;
    if (ex_store_data !== 32'd0) $display("FAIL reset_st got %h exp 0", ex_store_data); else n_pass++;
  endtask

  task automatic test_slt();
    no_fwd();
    set_id(2'b10, 6'b101010, 0, 1, 5'd3, 5'd4, 5'd9, 32'd5, 32'd9, 16'h0);
    step();
    n_checks += 5;
    if (ALU_control !== 3'd7) $display("FAIL slt_alu got %0d exp 7", ALU_control); else n_pass++;
    if (Read_data_1 !== 32'd5) $display("FAIL slt_rd1 got %h exp 5", Read_data_1); else n_pass++;
    if (Data_2 !== 32'd9) $display("FAIL slt_d2 got %h exp 9", Data_2); else n_pass++;
    if (ex_valid !== 1'b1) $display("FAIL slt_valid got %0b exp 1", ex_valid); else n_pass++;
    if (ex_rd !== 5'd9) $display("FAIL slt_rd got %0d exp 9", ex_rd); else n_pass++;
  endtask

  task automatic test_imm();
    set_id(2'b00, 6'd0, 1, 1, 5'd1, 5'd2, 5'd3, 32'h1234, 32'h5678, 16'hFFFC);
    step();
    n_checks += 3;
    if (Data_2 !== 32'hFFFFFFFC) $display("FAIL imm_d2 got %h exp fffffffc", Data_2); else n_pass++;
    if (ALU_control !== 3'd2) $display("FAIL imm_alu got %0d exp 2", ALU_control); else n_pass++;
    if (ex_store_data !== 32'h5678) $display("FAIL imm_st got %h exp 5678", ex_store_data); else n_pass++;
  endtask

  task automatic test_forwarding();
    set_id(2'b00, 6'd0, 0, 1, 5'd8, 5'd8, 5'd1, 32'hAA, 32'hBB, 16'h0);
    step();
    exmem_reg_write = 1; exmem_rd = 8; exmem_result = 32'h11;
    memwb_reg_write = 1; memwb_rd = 8; memwb_result = 32'h22;
    #1;
    n_checks += 4;
    if (Read_data_1 !== 32'h11) $display("FAIL fwd_both_rd1 got %h exp 11", Read_data_1); else n_pass++;
    if (Data_2 !== 32'h11) $display("FAIL fwd_both_d2 got %h exp 11", Data_2); else n_pass++;
    exmem_rd = 0;
    #1;
    if (Read_data_1 !== 32'h22) $display("FAIL fwd_wb_rd1 got %h exp 22", Read_data_1); else n_pass++;
    if (Data_2 !== 32'h22) $display("FAIL fwd_wb_d2 got %h exp 22", Data_2); else n_pass++;
    set_id(2'b00, 6'd0, 0, 1, 5'd0, 5'd0, 5'd1, 32'h33, 32'h44, 16'h0);
    exmem_rd = 0; memwb_rd = 0;
    step();
    n_checks += 1;
    if (Read_data_1 !== 32'h33) $display("FAIL fwd_r0 got %h exp 33", Read_data_1); else n_pass++;
    no_fwd();
  endtask

  task automatic test_stall_flush();
    set_id(2'b01, 6'd0, 0, 1, 5'd5, 5'd6, 5'd7, 32'h100, 32'h30, 16'h0);
    step();
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      set_id(2'b11, 6'($urandom), 1, 0, 5'($urandom), 5'($urandom), 5'd20, $urandom, $urandom, 16'($urandom));
      step();
      n_checks += 4;
      if (ALU_control !== 3'd6) $display("FAIL stall_alu got %0d exp 6", ALU_control); else n_pass++;
      if (Read_data_1 !== 32'h100) $display("FAIL stall_rd1 got %h exp 100", Read_data_1); else n_pass++;
      if (Data_2 !== 32'h30) $display("FAIL stall_d2 got %h exp 30", Data_2); else n_pass++;
      if (ex_rd !== 5'd7) $display("FAIL stall_rd got %0d exp 7", ex_rd); else n_pass++;
    end
    memwb_reg_write = 1; memwb_rd = 6; memwb_result = 32'h77;
    #1;
    n_checks += 1;
    if (Data_2 !== 32'h77) $display("FAIL stall_track got %h exp 77", Data_2); else n_pass++;
    flush = 1;
    step();
    flush = 0; stall = 0; no_fwd();
    n_checks += 4;
    if (ex_valid !== 1'b0) $display("FAIL flush_valid got %0b exp 0", ex_valid); else n_pass++;
    if (Read_data_1 !== 32'd0) $display("FAIL flush_rd1 got %h exp 0", Read_data_1); else n_pass++;
    if (Data_2 !== 32'd0) $display("FAIL flush_d2 got %h exp 0", Data_2); else n_pass++;
    if (ALU_control !== 3'd2) $display("FAIL flush_alu got %0d exp 2", ALU_control); else n_pass++;
  endtask

  task automatic test_illegal_reset();
    set_id(2'b10, 6'b000000, 0, 1, 5'd1, 5'd2, 5'd3, 32'h9, 32'h8, 16'h0);
    step();
    n_checks += 3;
    if (illegal_funct !== 1'b1) $display("FAIL ill_flag got %0b exp 1", illegal_funct); else n_pass++;
    if (ALU_control !== 3'd2) $display("FAIL ill_alu got %0d exp 2", ALU_control); else n_pass++;
    if (ex_reg_write !== 1'b0) $display("FAIL ill_rw got %0b exp 0", ex_reg_write); else n_pass++;
    set_id(2'b00, 6'd0, 0, 1, 5'd1, 5'd2, 5'd3, 32'h9, 32'h8, 16'h0);
    stall = 1;
    reset = 1;
    step();
    reset = 0; stall = 0;
    n_checks += 4;
    if (illegal_funct !== 1'b0) $display("FAIL rst_ill got %0b exp 0", illegal_funct); else n_pass++;
    if (ex_valid !== 1'b0) $display("FAIL rst_valid got %0b exp 0", ex_valid); else n_pass++;
    if (ex_rd !== 5'd0) $display("FAIL rst_rd got %0d exp 0", ex_rd); else n_pass++;
    if (Read_data_1 !== 32'd0) $display("FAIL rst_rd1 got %h exp 0", Read_data_1); else n_pass++;
  endtask

  task automatic test_random();
    logic [5:0] legal [5];
    legal = '{6'd32, 6'd34, 6'd36, 6'd37, 6'd42};
    for (int i = 0; i < 400; i++) begin
      reset = ($urandom_range(0, 40) == 0);
      stall = ($urandom_range(0, 3) == 0);
      flush = ($urandom_range(0, 9) == 0);
      id_valid = ($urandom_range(0, 5) != 0);
      id_alu_op = 2'($urandom);
      id_funct = ($urandom_range(0, 4) == 0) ? 6'($urandom) : legal[$urandom_range(0, 4)];
      id_alu_src = 1'($urandom); id_reg_write = 1'($urandom);
      id_rs = 5'($urandom_range(0, 3)); id_rt = 5'($urandom_range(0, 3));
      id_rd_dst = 5'($urandom);
      id_rs_data = $urandom; id_rt_data = $urandom; id_imm = 16'($urandom);
      step();
      exmem_reg_write = 1'($urandom); exmem_rd = 5'($urandom_range(0, 3)); exmem_result = $urandom;
      memwb_reg_write = 1'($urandom); memwb_rd = 5'($urandom_range(0, 3)); memwb_result = $urandom;
      #1;
      calc_exp();
      n_checks += 8;
      if (ex_valid !== m_valid) $display("FAIL rnd_valid i=%0d got %0b exp %0b", i, ex_valid, m_valid); else n_pass++;
      if (ex_reg_write !== m_rw) $display("FAIL rnd_rw i=%0d got %0b exp %0b", i, ex_reg_write, m_rw); else n_pass++;
      if (ex_rd !== m_rd) $display("FAIL rnd_rd i=%0d got %0d exp %0d", i, ex_rd, m_rd); else n_pass++;
      if (illegal_funct !== m_ill) $display("FAIL rnd_ill i=%0d got %0b exp %0b", i, illegal_funct, m_ill); else n_pass++;
      if (int'(ALU_control) != e_alu) $display("FAIL rnd_alu i=%0d got %0d exp %0d", i, ALU_control, e_alu); else n_pass++;
      if (Read_data_1 !== e_rd1) $display("FAIL rnd_rd1 i=%0d got %h exp %h", i, Read_data_1, e_rd1); else n_pass++;
      if (Data_2 !== e_d2) $display("FAIL rnd_d2 i=%0d got %h exp %h", i, Data_2, e_d2); else n_pass++;
      if (ex_store_data !== e_st) $display("FAIL rnd_st i=%0d got %h exp %h", i, ex_store_data, e_st); else n_pass++;
    end
    reset = 0; stall = 0; flush = 0;
  endtask

  initial begin
    test_reset();
    test_slt();
    test_imm();
    test_forwarding();
    test_stall_flush();
    test_illegal_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
